mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the Execute stage, sitting beside the combinational ALU and owning the HI/LO register pair. It accepts one operation at a time through a start/busy/done handshake and runs a shift-add multiplier or restoring divider over WIDTH cycles. The hazard unit stalls the pipeline on `busy` and reads results from `hi`/`lo`. Width is parametrised and signed support is a compile-time option.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be at least 4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only while `busy`=0.
- `op` input 3: operation code.
  - 000 MULTU, 001 DIVU, 010 MULT, 011 DIV.
  - 100 MTHI, 101 MTLO.
  - Other codes are a no-op.
- `a`, `b` input WIDTH: operands. `a` is multiplicand/dividend/move source; `b` is multiplier/divisor.
- `flush` input 1: synchronous abort of the operation in flight.
- `busy` output 1: high while in RUN or FIX.
- `done` output 1: one-cycle pulse when a multiply or divide commits.
- `div_zero` output 1: valid with `done`; high when a divide had `b`=0.
- `hi`, `lo` output WIDTH: architectural HI/LO registers.

## Operation
- State machine: IDLE, RUN, FIX.
- **IDLE, accept:** `start`=1 with a mul/div op latches operands and op, sets the iteration counter to WIDTH, and moves to RUN.
- **IDLE, moves:** `start`=1 with MTHI/MTLO writes `a` into `hi`/`lo` at that edge. No `busy`, no `done`.
- **IDLE, other:** any other code does nothing.
- **RUN:** one iteration per cycle; the counter decrements, and after WIDTH iterations the FSM moves to FIX.
  - Multiply: shift-add on operand magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- **FIX:** applies the sign fix-up, writes `hi`/`lo`, pulses `done`, returns to IDLE.
- **Results:**
  - Multiply: `hi` = product[2W-1:W], `lo` = product[W-1:0].
  - Divide: `lo` = quotient, `hi` = remainder.
- **Signed rules (MULT/DIV):**
  - Operands are converted to magnitudes.
  - Product and quotient are negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / −1 gives `lo`=MIN, `hi`=0.
- **Divide by zero:** still takes full latency; commits `lo`=all ones, `hi`=`a`, `div_zero`=1.
- **Flush:** `flush`=1 in RUN or FIX returns to IDLE at that edge. `hi`/`lo` are unchanged and there is no `done`. `flush` in IDLE has no effect, and `flush` takes priority over `start` in the same cycle.
- **Start while busy:** `start` during `busy`=1 is ignored and not queued.
- **Reset:** `rst_n` low at any time, including mid-operation, forces IDLE and clears all outputs immediately.

## Timing
- **Reset values:** `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE.
- **Accept edge** is edge 0.
- `busy` is high from after edge 0 through edge WIDTH+1.
- The FIX edge is edge WIDTH+1. `hi`/`lo`/`done`/`div_zero` update there, so `done` is high in the cycle after edge WIDTH+1.
- **Latency:** WIDTH+1 cycles from accept to result (33 for WIDTH=32).
- **Back-to-back:** `busy` is low in the same cycle as `done`, so a new `start` is accepted in the `done` cycle.
- **Move latency:** MTHI/MTLO results are visible the cycle after the write edge.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_SIGNED_EN`.
- **Defined:** MULT and DIV perform the signed fix-up described above.
- **Undefined:**
  - Sign-conversion and fix-up logic is omitted.
  - Op codes 010 and 011 execute as MULTU and DIVU respectively.
  - Latency is unchanged.

## Test plan
- Reset mid-RUN: `rst_n` low at cycle 10 -> `busy`=0, `hi`=`lo`=0 immediately; the next `start` is accepted normally.
- MULTU, `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, one `done` pulse.
- DIV (signed build), `a`=−7, `b`=2 -> `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- DIV (signed build), `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU, `a`=0x1234, `b`=0 -> `div_zero`=1, `lo`=0xFFFFFFFF, `hi`=0x1234.
- Extra `start` at cycle 5 of a MULTU, then `flush` at cycle 20 -> the extra `start` is ignored, no `done`, `hi`/`lo` retain prior values; MTLO 0xABCD next cycle -> `lo`=0xABCD with no `busy`.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier and restoring divider, WIDTH iterations per op.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV; without it op 010/011 run as MULTU/DIVU.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// RUN   | one multiply/divide iteration per cycle, counter counts down to 1
// FIX   | sign fix-up, HI/LO commit, done pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               dz;

    logic               accept;
    logic               move;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   hi_nx, lo_nx;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_r;
`endif

    assign accept = (state == IDLE) && start && !flush && !op[2];
    assign move   = (state == IDLE) && start && !flush && (op[2:1] == 2'b10);
    assign busy   = (state != IDLE);

`ifdef MULDIV_SIGNED_EN
    always_comb begin
        a_neg = op[1] & a[WIDTH-1];
        b_neg = op[1] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN: begin
                if (flush)                 state_nx = IDLE;
                else if (cnt == CW'(1))    state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd & {WIDTH{acc[0]}}};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opd};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_trial >= {1'b0, opd})
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
        prod_fix = acc;
        quo_fix  = acc[WIDTH-1:0];
        rem_fix  = acc[2*WIDTH-1:WIDTH];
`endif
        hi_nx = prod_fix[2*WIDTH-1:WIDTH];
        lo_nx = prod_fix[WIDTH-1:0];
        if (is_div) begin
            hi_nx = dz ? a_raw : rem_fix;
            lo_nx = dz ? {WIDTH{1'b1}} : quo_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (move) begin
                if (op[0]) lo <= a;
                else       hi <= a;
            end
            if (accept) begin
                cnt    <= CW'(WIDTH);
                is_div <= op[0];
                dz     <= op[0] && (b == '0);
                a_raw  <= a;
                if (op[0]) begin
                    acc <= {{WIDTH{1'b0}}, a_mag};
                    opd <= b_mag;
                end else begin
                    acc <= {{WIDTH{1'b0}}, b_mag};
                    opd <= a_mag;
                end
`ifdef MULDIV_SIGNED_EN
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
`endif
            end else if (state == RUN && !flush) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !flush) begin
                hi       <= hi_nx;
                lo       <= lo_nx;
                done     <= 1'b1;
                div_zero <= dz;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level behavioural model plus directed literal checks and random ops.
// Follows MULDIV_SIGNED_EN the same way the design does.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [W-1:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
    logic         e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0, p_dz = 1'b0;
    int           remaining = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Architectural result of one mul/div op from plain integer arithmetic
    function automatic void model_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        logic [63:0] p;
        longint      sp;
        int          sx, sy;
        bit          sg;
        sg  = SIGNED_EN && o[1];
        sx  = x;
        sy  = y;
        rdz = 1'b0;
        if (!o[0]) begin
            if (sg) begin
                sp = longint'(sx) * longint'(sy);
                p  = sp;
            end else begin
                p = {32'h0, x} * {32'h0, y};
            end
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == 0) begin
            rh  = x;
            rl  = 32'hFFFF_FFFF;
            rdz = 1'b1;
        end else if (sg) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                rl = x;
                rh = 0;
            end else begin
                rl = sx / sy;
                rh = sx % sy;
            end
        end else begin
            rl = x / y;
            rh = x % y;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_hi = '0; e_lo = '0; e_done = 1'b0; e_dz = 1'b0; remaining = 0;
        end else begin
            e_done = 1'b0;
            e_dz   = 1'b0;
            if (remaining > 0) begin
                if (flush) remaining = 0;
                else begin
                    remaining--;
                    if (remaining == 0) begin
                        e_hi = p_hi; e_lo = p_lo; e_done = 1'b1; e_dz = p_dz;
                    end
                end
            end else if (start && !flush) begin
                if (!op[2]) begin
                    model_res(op, a, b, p_hi, p_lo, p_dz);
                    remaining = W + 1;
                end else if (op == 3'b100) e_hi = a;
                else if (op == 3'b101) e_lo = a;
            end
        end
        e_busy = (remaining > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("div_zero", div_zero, e_dz);
            chk("hi", hi, e_hi);
            chk("lo", lo, e_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
        chk({name, " done seen"}, found, 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom_range(0, 255));
            default: return W'($urandom);
        endcase
    endfunction

    int lat;
    int ndone;

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset div_zero", div_zero, 1'b0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        issue(3'b100, 32'h1111, 32'h0);
        chk("mthi hi", hi, 32'h1111);
        issue(3'b101, 32'h2222, 32'h0);
        chk("mtlo lo", lo, 32'h2222);
        chk("move busy", busy, 1'b0);

        // reset in the middle of a multiply
        issue(3'b000, 32'd5, 32'd7);
        chk("run busy", busy, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(3'b000, 32'd5, 32'd7);
        wait_done("after reset", lat);
        chk("after reset lo", lo, 32'd35);

        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", lat);
        chk("multu latency", lat, 33);
        chk("multu hi", hi, 32'hFFFF_FFFE);
        chk("multu lo", lo, 32'h0000_0001);

        issue(3'b011, 32'hFFFF_FFF9, 32'd2);
        wait_done("div -7/2", lat);
`ifdef MULDIV_SIGNED_EN
        chk("div -7/2 lo", lo, 32'hFFFF_FFFD);
        chk("div -7/2 hi", hi, 32'hFFFF_FFFF);
`else
        chk("div -7/2 lo", lo, 32'h7FFF_FFFC);
        chk("div -7/2 hi", hi, 32'h0000_0001);
`endif

        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div min/-1", lat);
`ifdef MULDIV_SIGNED_EN
        chk("div min/-1 lo", lo, 32'h8000_0000);
        chk("div min/-1 hi", hi, 32'h0);
`else
        chk("div min/-1 lo", lo, 32'h0);
        chk("div min/-1 hi", hi, 32'h8000_0000);
`endif

        issue(3'b001, 32'h1234, 32'h0);
        wait_done("divu by zero", lat);
        chk("divu0 div_zero", div_zero, 1'b1);
        chk("divu0 lo", lo, 32'hFFFF_FFFF);
        chk("divu0 hi", hi, 32'h1234);

        // extra start mid-run, then flush: nothing commits
        issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) @(posedge clk);
        #1; start = 1'b1; op = 3'b001; a = 32'd99; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("flush no done", ndone, 0);
        chk("flush hi kept", hi, 32'h1234);
        chk("flush lo kept", lo, 32'hFFFF_FFFF);
        issue(3'b101, 32'hABCD, 32'h0);
        chk("mtlo after flush lo", lo, 32'hABCD);
        chk("mtlo after flush busy", busy, 1'b0);

        // start held high: second op accepted in the done cycle
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        op = 3'b001; a = 32'd100; b = 32'd7;
        wait_done("b2b first", lat);
        chk("b2b first lo", lo, 32'd12);
        @(posedge clk); #1 start = 1'b0;
        wait_done("b2b second", lat);
        chk("b2b second latency", lat, 33);
        chk("b2b second lo", lo, 32'd14);
        chk("b2b second hi", hi, 32'd2);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            if (e_busy) begin
                flush = ($urandom_range(0, 39) == 0);
                start = ($urandom_range(0, 7) == 0);
                op    = 3'($urandom);
                a     = pick();
            end else if ($urandom_range(0, 2) != 0) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                a     = pick();
                b     = pick();
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
